uart_tx_frame: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/baud_timer.sv | 28 ++
 rtl/uart_tx_frame.sv | 115 +++++++++++
 tb/tb_uart_tx_frame.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

   localparam int DATA_BITS  = 8;
   localparam int FRAME_BITS = 11;

   typedef enum logic [2:0] {
      IDLE,
      START,
      BITS,
      PAR,
      STOP,
      ACK
   } tx_state_t;

   function automatic int baud_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/baud_timer.sv
// Bit-period timer: counts 0..BAUD_DIV-1 and pulses timerDone on the last count.
module baud_timer #(
   parameter int BAUD_DIV = 5208
) (
   input  logic clk,
   input  logic clrTimer,
   output logic timerDone
);

   localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

   logic [CW-1:0] count_q, count_d;

   assign timerDone = (count_q == CW'(BAUD_DIV - 1));

   // Wrapping on timerDone keeps every bit period exactly BAUD_DIV cycles.
   always_comb begin
      count_d = count_q + 1'b1;
      if (clrTimer || timerDone) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      count_q <= count_d;
   end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit controller: one Send/Sent handshake per byte, 11-bit frame on Sout.
//
// state | meaning
// IDLE  | line high, waiting for Send
// START | start bit (low)
// BITS  | 8 data bits, LSB first
// PAR   | parity bit
// STOP  | stop bit (high)
// ACK   | Sent high until Send drops
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int CLK_FREQUENCY = 100_000_000,
   parameter int BAUD_RATE     = 19_200,
   parameter bit PARITY_ODD    = 1'b1
) (
   input  logic       clk,
   input  logic       Reset,
   input  logic       Send,
   input  logic [7:0] Din,
   output logic       Sent,
   output logic       Busy,
   output logic       Sout
);

   localparam int BAUD_DIV = baud_div(CLK_FREQUENCY, BAUD_RATE);

   tx_state_t  state_q, state_d;
   logic [7:0] shreg_q, shreg_d;
   logic [2:0] idx_q, idx_d;
   logic       par_q, par_d;
   logic       sout_q, sout_d;
   logic       sent_q, sent_d;
   logic       busy_q, busy_d;
   logic       clr_timer;
   logic       timer_done;

   assign clr_timer = Reset || (state_q == IDLE) || (state_q == ACK);

   baud_timer #(.BAUD_DIV(BAUD_DIV)) u_baud_timer (
      .clk       (clk),
      .clrTimer  (clr_timer),
      .timerDone (timer_done)
   );

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      idx_d   = idx_q;
      par_d   = par_q;
      case (state_q)
         IDLE: begin
            if (Send) begin
               shreg_d = Din;
               par_d   = PARITY_ODD ? ~^Din : ^Din;
               state_d = START;
            end
         end
         START: begin
            if (timer_done) begin
               idx_d   = '0;
               state_d = BITS;
            end
         end
         BITS: begin
            if (timer_done) begin
               shreg_d = shreg_q >> 1;
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'(DATA_BITS - 1)) begin
                  state_d = PAR;
               end
            end
         end
         PAR:     if (timer_done) state_d = STOP;
         STOP:    if (timer_done) state_d = ACK;
         ACK:     if (!Send) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs decode the next state so the flops present them glitch-free.
      case (state_d)
         START:   sout_d = 1'b0;
         BITS:    sout_d = shreg_d[0];
         PAR:     sout_d = par_d;
         default: sout_d = 1'b1;
      endcase
      sent_d = (state_d == ACK);
      busy_d = (state_d inside {START, BITS, PAR, STOP});
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q <= IDLE;
         shreg_q <= '0;
         idx_q   <= '0;
         par_q   <= 1'b0;
         sout_q  <= 1'b1;
         sent_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
         par_q   <= par_d;
         sout_q  <= sout_d;
         sent_q  <= sent_d;
         busy_q  <= busy_d;
      end
   end

   assign Sout = sout_q;
   assign Sent = sent_q;
   assign Busy = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: odd/even parity instances at BAUD_DIV=10, plus a default-rate spot check.
module tb_uart_tx_frame;
   import uart_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       Reset, Send, Send_def;
   logic [7:0] Din, Din_def;
   logic       sent_o, busy_o, sout_o;
   logic       sent_e, busy_e, sout_e;
   logic       sent_df, busy_df, sout_df;

   int   checks = 0;
   int   errors = 0;
   logic q_odd[$];
   logic q_even[$];

   uart_tx_frame #(.CLK_FREQUENCY(100), .BAUD_RATE(10), .PARITY_ODD(1'b1)) u_odd (
      .clk(clk), .Reset(Reset), .Send(Send), .Din(Din),
      .Sent(sent_o), .Busy(busy_o), .Sout(sout_o));

   uart_tx_frame #(.CLK_FREQUENCY(100), .BAUD_RATE(10), .PARITY_ODD(1'b0)) u_even (
      .clk(clk), .Reset(Reset), .Send(Send), .Din(Din),
      .Sent(sent_e), .Busy(busy_e), .Sout(sout_e));

   uart_tx_frame u_def (
      .clk(clk), .Reset(Reset), .Send(Send_def), .Din(Din_def),
      .Sent(sent_df), .Busy(busy_df), .Sout(sout_df));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   // Odd parity bit: set when the data has an even number of ones.
   function automatic logic odd_par(input logic [7:0] d);
      int n = 0;
      for (int i = 0; i < 8; i++) n += int'(d[i]);
      return (n % 2 == 0);
   endfunction

   task automatic push_frame(input logic [7:0] d);
      q_odd.push_back(1'b0);
      q_even.push_back(1'b0);
      for (int i = 0; i < 8; i++) begin
         q_odd.push_back(d[i]);
         q_even.push_back(d[i]);
      end
      q_odd.push_back(odd_par(d));
      q_even.push_back(!odd_par(d));
      q_odd.push_back(1'b1);
      q_even.push_back(1'b1);
   endtask

   task automatic do_frame(input logic [7:0] d, input int chg_at, input int extra);
      int busy_n;
      int lows;
      push_frame(d);
      @(negedge clk);
      Send = 1'b1;
      Din  = d;
      @(posedge clk);
      #1;
      busy_n = 0;
      for (int c = 0; c < 110; c++) begin
         @(negedge clk);
         if (busy_o) busy_n++;
         if (c == chg_at) Din = 8'h3C;
         if (c % 10 == 5) begin
            chk("sb_odd_avail", 32'(q_odd.size() != 0), 1);
            if (q_odd.size() != 0)
               chk($sformatf("odd_%02h_bit%0d", d, c / 10), sout_o, q_odd.pop_front());
            chk("sb_even_avail", 32'(q_even.size() != 0), 1);
            if (q_even.size() != 0)
               chk($sformatf("even_%02h_bit%0d", d, c / 10), sout_e, q_even.pop_front());
         end
      end
      chk("busy_width", busy_n, FRAME_BITS * 10);
      @(negedge clk);
      chk("sent_rise_odd", sent_o, 1);
      chk("sent_rise_even", sent_e, 1);
      chk("busy_fall", busy_o, 0);
      chk("sout_after_frame", sout_o, 1);
      busy_n = 0;
      lows   = 0;
      for (int c = 0; c < extra; c++) begin
         @(negedge clk);
         if (busy_o || busy_e || !sout_o) busy_n++;
         if (!sent_o) lows++;
      end
      chk("hold_no_second_frame", busy_n, 0);
      chk("hold_sent_high", lows, 0);
      Send = 1'b0;
      @(negedge clk);
      chk("sent_fall_odd", sent_o, 0);
      chk("sent_fall_even", sent_e, 0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog sim_time=%0t limit=1ms", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      Reset = 1'b1; Send = 1'b0; Din = 8'h00; Send_def = 1'b0; Din_def = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_sout", sout_o, 1);
      chk("rst_sent", sent_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_def_sent", sent_df, 0);
      Reset = 1'b0;
      n = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (!sout_o || busy_o) n++;
      end
      chk("idle_line_high", n, 0);

      do_frame(8'h55, -1, 0);
      do_frame(8'h00, -1, 0);
      do_frame(8'hFF, -1, 0);
      do_frame(8'h01, -1, 0);
      do_frame(8'h80, -1, 0);
      do_frame(8'h96, -1, 190);
      do_frame(8'h5A, -1, 0);
      do_frame(8'hA5, 35, 0);

      // Reset during data bit 3 of 0xC3 (bit 3 = 0).
      @(negedge clk);
      Send = 1'b1;
      Din  = 8'hC3;
      repeat (46) @(negedge clk);
      chk("mid_bit3_level", sout_o, 0);
      Reset = 1'b1;
      Send  = 1'b0;
      @(negedge clk);
      chk("midrst_sout", sout_o, 1);
      chk("midrst_busy", busy_o, 0);
      chk("midrst_sent", sent_o, 0);
      Reset = 1'b0;
      do_frame(8'h3C, -1, 0);

      // Reset asserted together with Send.
      @(negedge clk);
      Reset = 1'b1;
      Send  = 1'b1;
      Din   = 8'h0F;
      n = 0;
      repeat (3) begin
         @(negedge clk);
         if (busy_o || !sout_o) n++;
      end
      chk("rst_beats_send", n, 0);
      Send  = 1'b0;
      Reset = 1'b0;
      @(negedge clk);
      chk("post_rst_idle", busy_o, 0);

      // Default-rate start-bit width.
      @(negedge clk);
      Send_def = 1'b1;
      Din_def  = 8'h01;
      @(posedge clk);
      #1;
      Send_def = 1'b0;
      n = 0;
      while (n < 6000) begin
         @(negedge clk);
         if (n == 0) chk("def_busy", busy_df, 1);
         if (sout_df) break;
         n++;
      end
      chk("def_start_width", n, 5208);

      chk("sb_drained", q_odd.size() + q_even.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
